f2i128_iter: RTL
================

// Module: f2i128_iter
// PURPOSE
// - Iterative fp128 (IEEE 754 binary128) to integer converter; the inverse of the integer-to-float path.
// - Converts a 128-bit float to a signed or unsigned 128-bit integer under the selected rounding mode.
// - Reports overflow (saturating) and inexact results.
// - Multi-cycle shift datapath with a req/ready/done handshake; shares the FP unit clock/ce domain.
// PARAMETERS
// FPWID      128  float and integer width
// EXPW       15   exponent width; bias = 2**(EXPW-1)-1 = 16383; fraction width FMSB+1 = 112
// SHIFT_STEP 16   max alignment shift applied per ALIGN cycle (power of 2, 1..64)
// PORTS
// clk    in   1      clock, rising edge
// rst_n  in   1      synchronous reset, active-low
// ce     in   1      clock enable; when 0 all state/outputs hold
// req    in   1      start request; sampled when ce & ready
// op     in   1      1 = signed result, 0 = unsigned
// rm     in   3      rounding mode: 0 RNE, 1 RTZ, 2 +inf, 3 -inf, 4 away from zero, 5-7 RNE
// i      in   FPWID  float input
// ready  out  1      1 = state IDLE (combinational from state)
// done   out  1      one-cycle pulse, o/ovf/inx valid
// o      out  FPWID  integer result; held until next accept
// ovf    out  1      out of range / NaN / Inf; o saturated
// inx    out  1      inexact (rounding bits nonzero, no overflow)
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state=IDLE, o=0, done=0, ovf=0, inx=0; overrides ce.
// - Reset mid-operation drops the conversion; no done pulse follows.
// - States: IDLE, ALIGN, ROUND, FIX, DONE; transitions only when ce=1.
// - Accept (IDLE & req) latches op, rm, sign s, exponent e, and m = {e!=0, frac} (113 bits).
// - Unbiased exponent ue = e - 16383 (denormals: ue = -16382, hidden bit 0).
// - Special: e = all-ones, or ue >= 128 -> next state DONE directly:
//   - NaN: o = op ? 0x7FFF..F : all-ones, ovf=1.
//   - Inf / large, s=0: o = op ? 0x7FFF..F : all-ones, ovf=1.
//   - Inf / large, s=1: o = op ? 0x8000..0 : 0, ovf=1.
// - Shift amount SH:
//   - ue >= 112: left shift, SH = ue-112 (exact).
//   - ue < 112: right shift, SH = min(112-ue, 115).
// - N = ceil(SH/SHIFT_STEP). Accept -> ALIGN if N>0, else ROUND.
// - ALIGN: each cycle shifts by min(SHIFT_STEP, remaining).
//   - Right shifts move bits into r (first fraction bit) and OR the rest into sticky s_b.
//   - Leaves ALIGN for ROUND when remaining = 0.
// - ROUND: g = int lsb; rnd per rm:
//   - 0 RNE: r&(g|s_b); 1 RTZ: 0; 2 +inf: (r|s_b)&~s; 3 -inf: (r|s_b)&s; 4 away: r|s_b.
//   - mag = int + rnd, FPWID+1 bits wide (carry kept).
// - FIX: range check, then 2's-complement if s.
//   - signed: s=0 & mag >= 2**127 -> 0x7FFF..F, ovf=1; s=1 & mag > 2**127 -> 0x8000..0, ovf=1.
//   - unsigned: mag >= 2**128 -> all-ones, ovf=1; s=1 & mag != 0 -> 0, ovf=1.
//   - inx = (r|s_b) & ~ovf.
// - DONE: done=1 for exactly one cycle -> IDLE. A new req is accepted only in IDLE; req while busy is ignored.
// - Latency from accept edge to done=1: special 1 cycle; normal N+3 cycles.
//   - Max normal latency = ceil(115/SHIFT_STEP)+3.
// - ce=0 at any state stretches latency; done stays high while ce=0 in DONE.
// TESTING
// - 1.0 (0x3FFF_0..0), op=1, rm=0 -> o=1, inx=0, ovf=0; done 10 cycles after accept (N=7).
// - 2.5 (0x4000_4000_0..0), op=1: rm=0 -> 2, rm=4 -> 3, rm=2 -> 3, rm=1 -> 2; inx=1 in all cases.
// - -2.5, op=1, rm=3 -> 0xFFFF..FFFD, inx=1; same input, op=0 -> o=0, ovf=1.
// - 2**127 (0x407E_0..0): op=1 -> 0x7FFF..F, ovf=1; op=0 -> 0x8000..0, ovf=0.
//   - -2**127, op=1 -> 0x8000..0, ovf=0.
// - NaN (0x7FFF_8000_0..0), op=1 -> 0x7FFF..F, ovf=1, done 1 cycle after accept.
//   - A second req asserted while busy produces no extra done.
// - 1.0 accepted, rst_n=0 during ALIGN -> ready=1 next cycle, o=0, no done pulse.
//   - Smallest denormal, rm=2, s=0 -> o=1, inx=1.

Source files
------------

// File: rtl/f2i128_iter.sv
// f2i128_iter: iterative binary128 float -> 128-bit integer converter.
// The significand is aligned by a multi-cycle barrel shifter that moves at most
// SHIFT_STEP bit positions per ALIGN cycle. The result is then rounded and
// range-checked, and the output saturates on overflow.
// Ports:
//   clk, rst_n (sync, active-low), ce (clock enable; holds all state when low)
//   req/ready  start handshake; req is sampled when ce & ready
//   op         1 = signed result, 0 = unsigned
//   rm         rounding mode: 0 RNE, 1 RTZ, 2 +inf, 3 -inf, 4 away; 5-7 use RNE
//   i          float input
//   done       result-valid strobe, high for one enabled cycle
//   o/ovf/inx  integer result, out-of-range flag, inexact flag
module f2i128_iter #(
  parameter int FPWID      = 128,
  parameter int EXPW       = 15,
  parameter int SHIFT_STEP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             req,
  input  logic             op,
  input  logic [2:0]       rm,
  input  logic [FPWID-1:0] i,
  output logic             ready,
  output logic             done,
  output logic [FPWID-1:0] o,
  output logic             ovf,
  output logic             inx
);
  localparam int FW    = FPWID - EXPW - 1;           // fraction width (112)
  localparam int MW    = FW + 1;                     // significand width with hidden bit
  localparam int BIAS  = 2**(EXPW-1) - 1;
  localparam int SHMAX = FW + 3;                     // larger right shifts only feed sticky
  localparam int SHW   = $clog2(SHMAX + 1);
  localparam logic [31:0] LEFT_E = 32'(BIAS + FW);   // exponent at which the shift turns left
  localparam logic [31:0] SPEC_E = 32'(BIAS + FPWID);
  localparam logic [FPWID-1:0] SMAX = {1'b0, {(FPWID-1){1'b1}}};
  localparam logic [FPWID-1:0] SMIN = {1'b1, {(FPWID-1){1'b0}}};
  localparam logic [FPWID:0]   MAG_MIN = {2'b01, {(FPWID-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ROUND, FIX, DONE} state_t;

  state_t           state_q;
  logic             op_q, sgn_q, left_q, r_q, sb_q;
  logic [2:0]       rm_q;
  logic [SHW-1:0]   rem_q;
  logic [FPWID-1:0] acc_q, o_q;
  logic [FPWID:0]   mag_q;
  logic             done_q, ovf_q, inx_q;

  // ---- input decode (used only on the accept cycle) ----
  logic             sgn_in, in_nan, in_spec, in_left;
  logic [EXPW-1:0]  exp_in;
  logic [FW-1:0]    frac_in;
  logic [31:0]      e32, ee, dsh;
  logic [SHW-1:0]   sh_in;
  logic [FPWID-1:0] m_in, spec_o;

  always_comb begin
    sgn_in  = i[FPWID-1];
    exp_in  = i[FPWID-2 -: EXPW];
    frac_in = i[FW-1:0];
    e32     = 32'(exp_in);
    ee      = (exp_in == '0) ? 32'd1 : e32;   // denormals share the minimum exponent
    in_nan  = (&exp_in) && (|frac_in);
    in_spec = (&exp_in) || (e32 >= SPEC_E);
    in_left = (e32 >= LEFT_E);
    dsh     = in_left ? (e32 - LEFT_E) : (LEFT_E - ee);
    if (dsh > 32'(SHMAX)) dsh = 32'(SHMAX);
    sh_in   = SHW'(dsh);
    m_in    = {{(FPWID-MW){1'b0}}, (exp_in != '0), frac_in};
    // NaN saturates positive regardless of its sign bit
    if (in_nan || !sgn_in) spec_o = op ? SMAX : '1;
    else                   spec_o = op ? SMIN : '0;
  end

  // ---- one alignment step ----
  logic [SHW-1:0]   k;
  logic [FPWID-1:0] mask, tmp, acc_d;
  logic             r_d, sb_d;

  always_comb begin
    k     = (rem_q > SHW'(SHIFT_STEP)) ? SHW'(SHIFT_STEP) : rem_q;
    mask  = (FPWID'(1) << k) - FPWID'(1);
    acc_d = left_q ? (acc_q << k) : (acc_q >> k);
    tmp   = acc_q >> (k - SHW'(1));
    // right shift: last bit out becomes the round bit, the old round bit and
    // all lower shifted-out bits fold into sticky
    r_d   = left_q ? r_q  : tmp[0];
    sb_d  = left_q ? sb_q : (sb_q | r_q | (|(acc_q & (mask >> 1))));
  end

  // ---- rounding and range fix-up ----
  logic             rnd;
  logic [FPWID:0]   mag_d;
  logic [FPWID-1:0] fix_o;
  logic             fix_ovf;

  always_comb begin
    case (rm_q)
      3'd1:    rnd = 1'b0;
      3'd2:    rnd = (r_q | sb_q) & ~sgn_q;
      3'd3:    rnd = (r_q | sb_q) & sgn_q;
      3'd4:    rnd = r_q | sb_q;
      default: rnd = r_q & (acc_q[0] | sb_q);
    endcase
    mag_d = {1'b0, acc_q} + (FPWID+1)'(rnd);

    fix_ovf = 1'b0;
    fix_o   = sgn_q ? (~mag_q[FPWID-1:0] + FPWID'(1)) : mag_q[FPWID-1:0];
    if (op_q) begin
      if (!sgn_q && mag_q >= MAG_MIN)     begin fix_o = SMAX; fix_ovf = 1'b1; end
      else if (sgn_q && mag_q > MAG_MIN)  begin fix_o = SMIN; fix_ovf = 1'b1; end
    end else begin
      // a negative nonzero value has no unsigned encoding; clamp to 0
      if (sgn_q && mag_q != '0)           begin fix_o = '0;   fix_ovf = 1'b1; end
      else if (mag_q[FPWID])              begin fix_o = '1;   fix_ovf = 1'b1; end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= 1'b0; sgn_q <= 1'b0; left_q <= 1'b0; r_q <= 1'b0; sb_q <= 1'b0;
      rm_q <= '0; rem_q <= '0; acc_q <= '0; mag_q <= '0;
      o_q <= '0; done_q <= 1'b0; ovf_q <= 1'b0; inx_q <= 1'b0;
    end else if (ce) begin
      case (state_q)
        IDLE: if (req) begin
          op_q  <= op;  rm_q <= rm;  sgn_q <= sgn_in;  left_q <= in_left;
          acc_q <= m_in; r_q <= 1'b0; sb_q <= 1'b0;   rem_q  <= sh_in;
          if (in_spec) begin
            o_q <= spec_o; ovf_q <= 1'b1; inx_q <= 1'b0; done_q <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= (sh_in != '0) ? ALIGN : ROUND;
          end
        end
        ALIGN: begin
          acc_q <= acc_d; r_q <= r_d; sb_q <= sb_d;
          rem_q <= rem_q - k;
          if (rem_q == k) state_q <= ROUND;
        end
        ROUND: begin
          mag_q   <= mag_d;
          state_q <= FIX;
        end
        FIX: begin
          o_q    <= fix_o;
          ovf_q  <= fix_ovf;
          inx_q  <= (r_q | sb_q) & ~fix_ovf;
          done_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign o     = o_q;
  assign ovf   = ovf_q;
  assign inx   = inx_q;
endmodule
